debug_commit_serializer: RTL and testbench
==========================================

# debug_commit_serializer

Parametrised commit-trace serializer between a multi-issue core's writeback stage and the single-commit debug port (`debug_wb_pc`, `debug_wb_rf_wen`, `debug_wb_rf_wnum`, `debug_wb_rf_wdata`).

- **Input:** up to NCH retired instructions per cycle, lane 0 oldest.
- **Buffering:** a DEPTH-entry FIFO holds them in program order.
- **Output:** exactly one commit per cycle to the trace comparator.
- **Backpressure:** stalls writeback when the free space cannot hold a full batch.

It replaces direct wiring of core writeback signals to the debug ports once the core retires more than one instruction per cycle.

## Interface
Parameters:
- NCH, default 2: commit lanes per cycle. Legal range 1..4.
- DEPTH, default 8: FIFO entries. Power of two, DEPTH >= 2*NCH.
- FILTER_NOWRITE, default 0: when 1, lanes with wen==0 or wnum==0 are dropped at push.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- in_valid  in  NCH  per-lane commit valid.
- in_pc  in  NCH×32  per-lane commit PC.
- in_wen  in  NCH×4  per-lane register-file write strobe.
- in_wnum  in  NCH×5  per-lane destination register.
- in_wdata  in  NCH×32  per-lane write data.
- in_ready  out  1  batch accepted this cycle when high.
- debug_wb_valid  out  1  an entry is presented this cycle.
- debug_wb_pc  out  32  committed PC.
- debug_wb_rf_wen  out  4  write strobe; 4'b0 when not valid.
- debug_wb_rf_wnum  out  5  destination register.
- debug_wb_rf_wdata  out  32  write data.
- occupancy  out  $clog2(DEPTH+1)  entries currently held in the FIFO, excluding the output register.

## Operation
**Push**
- A lane is kept when `in_valid[i]` is set.
- With FILTER_NOWRITE=1, a lane is kept only if `in_valid[i]` is set and `in_wen[i]!=0` and `in_wnum[i]!=0`.
- When `in_ready` is high, all kept lanes are written in one cycle, compacted and in ascending lane order, at consecutive slots starting at the write pointer.
- Gaps between valid lanes are never stored.
- When `in_ready` is low, inputs are ignored. Upstream holds the batch until `in_ready` is high.

**in_ready**
- `in_ready = (DEPTH - occupancy) >= NCH`, computed from the registered occupancy only.
- A pop in the same cycle does not increase the credit.

**Pop**
- Each cycle with occupancy>0, the head entry is loaded into the output registers and `debug_wb_valid` is set to 1.
- With occupancy==0, `debug_wb_valid` and `debug_wb_rf_wen` are set to 0. pc, wnum and wdata hold their previous values.
- The debug port has no backpressure: pop is unconditional.

**Pointers and occupancy**
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Occupancy is tracked as a separate counter.
- Each cycle: occupancy_next = occupancy + pushed_count − popped. pushed_count is 0..NCH and popped is 0 or 1.

**Simultaneous events**
- Push and pop in the same cycle are both performed.
- A push of zero kept lanes while `in_ready` is high is legal and leaves occupancy unchanged except for the pop.

**Ordering**
- Output order equals program order: batch order first, then lane order within a batch.

## Timing
**Reset values** (asynchronous assert, immediate on resetn low):
- pointers, occupancy: 0
- debug_wb_valid: 0
- debug_wb_rf_wen: 4'b0
- debug_wb_pc: 32'h0
- debug_wb_rf_wnum: 5'h0
- debug_wb_rf_wdata: 32'h0
- in_ready: 1, since DEPTH >= NCH

A batch that is mid-flight when reset asserts is discarded.

**Latency**
- A lane pushed on edge t into an empty FIFO appears on the debug outputs after edge t+1, i.e. 2 cycles from input to output.
- The k-th entry of a batch appears k cycles after the first.

**Throughput and full condition**
- Sustained output is 1 entry per cycle.
- With all lanes valid every cycle, in_ready deasserts once occupancy > DEPTH−NCH.
- in_ready is combinational from registers only, with no path from in_valid.

## Test plan
- **Reset:** assert resetn=0 mid-stream → all outputs zero and in_ready=1 immediately. After release, the first push of pc=0xBFC00000, wen=F, wnum=2 appears 2 cycles later.
- **Compaction:** NCH=2, single cycle with in_valid=2'b10, lane1 pc=0x100 → exactly one entry, pc=0x100, output 2 cycles later. No empty slot is emitted.
- **Ordering:** NCH=2, three consecutive batches (0x0,0x4), (0x8,0xC), (0x10,0x14) → outputs 0x0,0x4,0x8,0xC,0x10,0x14 on consecutive cycles.
- **Backpressure:** DEPTH=8, NCH=2, both lanes valid every cycle.
  - in_ready falls once occupancy reaches 7.
  - Occupancy never exceeds 8.
  - No entry is lost or duplicated over 100 instructions; the scoreboard compares PC order.
- **Filter:** FILTER_NOWRITE=1, lanes (wen=0, wnum=3) and (wen=F, wnum=0) and (wen=F, wnum=5, wdata=0x1234) → only the wnum=5 entry is emitted, with wdata=0x1234.
- **Wrap-around and idle:** push 20 single entries with random gaps → pointers wrap with correct order. While idle, debug_wb_valid=0 and wen=0, and pc holds its last value.

Source files
------------

// File: rtl/debug_commit_serializer.sv
// Funnels up to NCH retired instructions per cycle into the single-commit
// debug trace port through a DEPTH-entry FIFO that preserves program order.
module debug_commit_serializer #(
  parameter int NCH            = 2,
  parameter int DEPTH          = 8,
  parameter bit FILTER_NOWRITE = 1'b0
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NCH-1:0]             in_valid,
  input  logic [NCH*32-1:0]          in_pc,
  input  logic [NCH*4-1:0]           in_wen,
  input  logic [NCH*5-1:0]           in_wnum,
  input  logic [NCH*32-1:0]          in_wdata,
  output logic                       in_ready,
  output logic                       debug_wb_valid,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } entry_t;

  entry_t         mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [NCH-1:0] keep;
  logic [PW-1:0]  slot [NCH];
  logic [OW-1:0]  push_cnt;
  logic           pop;

  // Credit comes from the registered occupancy only, so a same-cycle pop never
  // widens the window and in_ready has no path from the inputs.
  assign in_ready = (occupancy <= OW'(DEPTH - NCH));
  assign pop      = (occupancy != '0);

  // Running count of kept lanes gives each kept lane its compacted slot.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      keep[i] = in_valid[i] &&
                (!FILTER_NOWRITE || ((in_wen[i*4 +: 4] != 4'h0) && (in_wnum[i*5 +: 5] != 5'h0)));
      slot[i] = wr_ptr + PW'(push_cnt);
      if (keep[i]) push_cnt = push_cnt + OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (in_ready) begin
      for (int i = 0; i < NCH; i++) begin
        if (keep[i]) begin
          mem[slot[i]] <= '{pc:    in_pc[i*32 +: 32],
                            wen:   in_wen[i*4 +: 4],
                            wnum:  in_wnum[i*5 +: 5],
                            wdata: in_wdata[i*32 +: 32]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      occupancy         <= '0;
      debug_wb_valid    <= 1'b0;
      debug_wb_pc       <= 32'h0;
      debug_wb_rf_wen   <= 4'h0;
      debug_wb_rf_wnum  <= 5'h0;
      debug_wb_rf_wdata <= 32'h0;
    end else begin
      if (in_ready) wr_ptr <= wr_ptr + PW'(push_cnt);
      occupancy <= occupancy + (in_ready ? push_cnt : OW'(0)) - OW'(pop);
      if (pop) begin
        debug_wb_valid    <= 1'b1;
        debug_wb_pc       <= mem[rd_ptr].pc;
        debug_wb_rf_wen   <= mem[rd_ptr].wen;
        debug_wb_rf_wnum  <= mem[rd_ptr].wnum;
        debug_wb_rf_wdata <= mem[rd_ptr].wdata;
        rd_ptr            <= rd_ptr + PW'(1);
      end else begin
        debug_wb_valid    <= 1'b0;
        debug_wb_rf_wen   <= 4'h0;
      end
    end
  end

endmodule

// File: tb/tb_debug_commit_serializer.sv
// Bench for debug_commit_serializer: a queue-based reference model of the FIFO
// plus directed checks of reset, compaction, ordering, backpressure and filtering.
module tb_debug_commit_serializer;
  localparam int NCH   = 2;
  localparam int DEPTH = 8;
  localparam int OW    = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]    in_valid;
  logic [NCH*32-1:0] in_pc;
  logic [NCH*4-1:0]  in_wen;
  logic [NCH*5-1:0]  in_wnum;
  logic [NCH*32-1:0] in_wdata;
  logic              in_ready;
  logic              debug_wb_valid;
  logic [31:0]       debug_wb_pc;
  logic [3:0]        debug_wb_rf_wen;
  logic [4:0]        debug_wb_rf_wnum;
  logic [31:0]       debug_wb_rf_wdata;
  logic [OW-1:0]     occupancy;

  logic [NCH-1:0]    f_in_valid;
  logic [NCH*32-1:0] f_in_pc;
  logic [NCH*4-1:0]  f_in_wen;
  logic [NCH*5-1:0]  f_in_wnum;
  logic [NCH*32-1:0] f_in_wdata;
  logic              f_in_ready;
  logic              f_valid;
  logic [31:0]       f_pc;
  logic [3:0]        f_wen;
  logic [4:0]        f_wnum;
  logic [31:0]       f_wdata;
  logic [OW-1:0]     f_occupancy;

  debug_commit_serializer #(.NCH(NCH), .DEPTH(DEPTH), .FILTER_NOWRITE(1'b0)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_pc(in_pc), .in_wen(in_wen), .in_wnum(in_wnum), .in_wdata(in_wdata),
    .in_ready(in_ready), .debug_wb_valid(debug_wb_valid), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata), .occupancy(occupancy)
  );

  debug_commit_serializer #(.NCH(NCH), .DEPTH(DEPTH), .FILTER_NOWRITE(1'b1)) dut_filt (
    .clk(clk), .resetn(resetn),
    .in_valid(f_in_valid), .in_pc(f_in_pc), .in_wen(f_in_wen), .in_wnum(f_in_wnum), .in_wdata(f_in_wdata),
    .in_ready(f_in_ready), .debug_wb_valid(f_valid), .debug_wb_pc(f_pc),
    .debug_wb_rf_wen(f_wen), .debug_wb_rf_wnum(f_wnum),
    .debug_wb_rf_wdata(f_wdata), .occupancy(f_occupancy)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } entry_t;

  entry_t q[$];
  entry_t m_out;
  entry_t m_e;
  logic   m_valid;
  bit     m_ready;
  int     errors = 0;
  int     checks = 0;

  // Reference model: a plain queue; one pop from the old contents, then the
  // accepted batch appended in lane order, credit judged from the old size.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q.delete();
      m_valid = 1'b0;
      m_out   = '0;
    end else begin
      m_ready = (DEPTH - q.size()) >= NCH;
      if (q.size() > 0) begin
        m_valid = 1'b1;
        m_out   = q.pop_front();
      end else begin
        m_valid   = 1'b0;
        m_out.wen = 4'h0;
      end
      if (m_ready) begin
        for (int i = 0; i < NCH; i++) begin
          if (in_valid[i]) begin
            m_e.pc    = in_pc[i*32 +: 32];
            m_e.wen   = in_wen[i*4 +: 4];
            m_e.wnum  = in_wnum[i*5 +: 5];
            m_e.wdata = in_wdata[i*32 +: 32];
            q.push_back(m_e);
          end
        end
      end
    end
  end

  task automatic set_lane(input int i, input logic v, input logic [31:0] pc, input logic [3:0] wen,
                          input logic [4:0] wnum, input logic [31:0] wdata);
    in_valid[i]          = v;
    in_pc[i*32 +: 32]    = pc;
    in_wen[i*4 +: 4]     = wen;
    in_wnum[i*5 +: 5]    = wnum;
    in_wdata[i*32 +: 32] = wdata;
  endtask

  task automatic set_flane(input int i, input logic v, input logic [31:0] pc, input logic [3:0] wen,
                           input logic [4:0] wnum, input logic [31:0] wdata);
    f_in_valid[i]          = v;
    f_in_pc[i*32 +: 32]    = pc;
    f_in_wen[i*4 +: 4]     = wen;
    f_in_wnum[i*5 +: 5]    = wnum;
    f_in_wdata[i*32 +: 32] = wdata;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = '0;
    do begin
      @(negedge clk);
      n++;
    end while ((q.size() != 0 || m_valid) && n < 50);
    checks++;
    if (q.size() != 0 || m_valid || debug_wb_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain: valid=%b occupancy=%0d, required idle after %0d cycles", debug_wb_valid, occupancy, n);
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++)
        set_lane(i, 1'($urandom), $urandom, 4'($urandom), 5'($urandom), $urandom);
    end
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({debug_wb_valid, debug_wb_rf_wen, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata} !== 74'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got v=%b wen=%h pc=%h wnum=%0d wdata=%h, required all zero",
               debug_wb_valid, debug_wb_rf_wen, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata);
    end
    checks++;
    if (in_ready !== 1'b1 || occupancy !== '0) begin
      errors++;
      $display("[TB] FAIL reset_credit: got ready=%b occupancy=%0d, required ready=1 occupancy=0", in_ready, occupancy);
    end
    in_valid = '0;
    @(negedge clk);
    resetn = 1'b1;
    set_lane(0, 1'b1, 32'hBFC00000, 4'hF, 5'd2, 32'hCAFE0001);
    @(negedge clk);
    in_valid = '0;
    checks++;
    if (debug_wb_valid !== 1'b0 || occupancy !== OW'(1)) begin
      errors++;
      $display("[TB] FAIL reset_first_wait: got v=%b occupancy=%0d, required v=0 occupancy=1", debug_wb_valid, occupancy);
    end
    @(negedge clk);
    checks++;
    if (debug_wb_valid !== 1'b1 || debug_wb_pc !== 32'hBFC00000 || debug_wb_rf_wen !== 4'hF ||
        debug_wb_rf_wnum !== 5'd2 || debug_wb_rf_wdata !== 32'hCAFE0001) begin
      errors++;
      $display("[TB] FAIL reset_first_push: got v=%b pc=%h wen=%h wnum=%0d wdata=%h, required v=1 pc=bfc00000 wen=f wnum=2 wdata=cafe0001",
               debug_wb_valid, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata);
    end
  endtask

  task automatic test_compaction();
    drain();
    set_lane(0, 1'b0, 32'h0DEAD, 4'hF, 5'd7, 32'h0);
    set_lane(1, 1'b1, 32'h100, 4'h3, 5'd9, 32'h55AA);
    @(negedge clk);
    in_valid = '0;
    checks++;
    if (occupancy !== OW'(1) || debug_wb_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL compact_store: got occupancy=%0d v=%b, required occupancy=1 v=0", occupancy, debug_wb_valid);
    end
    @(negedge clk);
    checks++;
    if (debug_wb_valid !== 1'b1 || debug_wb_pc !== 32'h100 || debug_wb_rf_wnum !== 5'd9 || debug_wb_rf_wdata !== 32'h55AA) begin
      errors++;
      $display("[TB] FAIL compact_out: got v=%b pc=%h wnum=%0d wdata=%h, required v=1 pc=100 wnum=9 wdata=55aa",
               debug_wb_valid, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata);
    end
    @(negedge clk);
    checks++;
    if (debug_wb_valid !== 1'b0 || debug_wb_rf_wen !== 4'h0 || occupancy !== '0) begin
      errors++;
      $display("[TB] FAIL compact_no_gap: got v=%b wen=%h occupancy=%0d, required v=0 wen=0 occupancy=0",
               debug_wb_valid, debug_wb_rf_wen, occupancy);
    end
  endtask

  task automatic test_ordering();
    logic [31:0] got_pc[$];
    int          got_cyc[$];
    drain();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (debug_wb_valid) begin
        got_pc.push_back(debug_wb_pc);
        got_cyc.push_back(c);
      end
      if (c < 3) begin
        set_lane(0, 1'b1, 32'(c*8),     4'hF, 5'($urandom_range(1, 31)), $urandom);
        set_lane(1, 1'b1, 32'(c*8 + 4), 4'hF, 5'($urandom_range(1, 31)), $urandom);
      end else begin
        in_valid = '0;
      end
    end
    checks++;
    if (got_pc.size() != 6) begin
      errors++;
      $display("[TB] FAIL order_count: got %0d entries, required 6", got_pc.size());
    end
    for (int k = 0; k < got_pc.size() && k < 6; k++) begin
      checks++;
      if (got_pc[k] !== 32'(k*4) || got_cyc[k] != got_cyc[0] + k) begin
        errors++;
        $display("[TB] FAIL order_entry%0d: got pc=%h at offset %0d, required pc=%h at offset %0d",
                 k, got_pc[k], got_cyc[k] - got_cyc[0], k*4, k);
      end
    end
  endtask

  task automatic test_backpressure();
    int          issued = 0;
    int          got = 0;
    int          cyc = 0;
    logic        prev_ready = 1'b0;
    bit          saw_stall = 1'b0;
    logic [31:0] exp_pc;
    drain();
    while (got < 100 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      checks++;
      if ({debug_wb_valid, debug_wb_rf_wen, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata} !==
          {m_valid, m_out.wen, m_out.pc, m_out.wnum, m_out.wdata}) begin
        errors++;
        $display("[TB] FAIL bp_out: got v=%b pc=%h wen=%h wnum=%0d wdata=%h, required v=%b pc=%h wen=%h wnum=%0d wdata=%h",
                 debug_wb_valid, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
                 m_valid, m_out.pc, m_out.wen, m_out.wnum, m_out.wdata);
      end
      checks++;
      if (occupancy !== OW'(q.size()) || in_ready !== ((DEPTH - q.size()) >= NCH) || occupancy > OW'(DEPTH)) begin
        errors++;
        $display("[TB] FAIL bp_credit: got occupancy=%0d ready=%b, required occupancy=%0d ready=%b",
                 occupancy, in_ready, q.size(), (DEPTH - q.size()) >= NCH);
      end
      if (occupancy == OW'(DEPTH - NCH + 1)) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL bp_ready_at_7: got ready=%b, required 0", in_ready);
        end
      end
      if (debug_wb_valid === 1'b1) begin
        exp_pc = 32'h1000 + 32'(got*4);
        checks++;
        if (debug_wb_pc !== exp_pc) begin
          errors++;
          $display("[TB] FAIL bp_seq%0d: got pc=%h, required %h", got, debug_wb_pc, exp_pc);
        end
        got++;
      end
      if (in_ready !== 1'b1) saw_stall = 1'b1;
      if (in_valid == '0 || prev_ready) begin
        if (in_valid != '0) issued += 2;
        if (issued < 100) begin
          set_lane(0, 1'b1, 32'h1000 + 32'(issued*4),     4'($urandom), 5'($urandom), $urandom);
          set_lane(1, 1'b1, 32'h1000 + 32'(issued*4 + 4), 4'($urandom), 5'($urandom), $urandom);
        end else begin
          in_valid = '0;
        end
      end
      prev_ready = in_ready;
    end
    in_valid = '0;
    checks++;
    if (got != 100) begin
      errors++;
      $display("[TB] FAIL bp_total: got %0d entries in %0d cycles, required 100", got, cyc);
    end
    checks++;
    if (!saw_stall) begin
      errors++;
      $display("[TB] FAIL bp_stall: in_ready never fell, required a stall");
    end
  endtask

  task automatic test_filter();
    int n = 0;
    f_in_valid = '0;
    @(negedge clk);
    set_flane(0, 1'b1, 32'h200, 4'h0, 5'd3, 32'hAAAA);
    set_flane(1, 1'b1, 32'h204, 4'hF, 5'd0, 32'hBBBB);
    @(negedge clk);
    checks++;
    if (f_occupancy !== '0) begin
      errors++;
      $display("[TB] FAIL filter_drop: got occupancy=%0d, required 0", f_occupancy);
    end
    set_flane(0, 1'b1, 32'h208, 4'hF, 5'd5, 32'h1234);
    set_flane(1, 1'b0, 32'h20C, 4'hF, 5'd6, 32'hCCCC);
    @(negedge clk);
    f_in_valid = '0;
    checks++;
    if (f_occupancy !== OW'(1)) begin
      errors++;
      $display("[TB] FAIL filter_keep: got occupancy=%0d, required 1", f_occupancy);
    end
    for (int c = 0; c < 6; c++) begin
      if (f_valid === 1'b1) begin
        n++;
        checks++;
        if (f_pc !== 32'h208 || f_wen !== 4'hF || f_wnum !== 5'd5 || f_wdata !== 32'h1234) begin
          errors++;
          $display("[TB] FAIL filter_entry: got pc=%h wen=%h wnum=%0d wdata=%h, required pc=208 wen=f wnum=5 wdata=1234",
                   f_pc, f_wen, f_wnum, f_wdata);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("[TB] FAIL filter_count: got %0d entries, required 1", n);
    end
  endtask

  task automatic test_wrap_idle();
    logic [31:0] sent_pc[$];
    int          got = 0;
    int          gap = 0;
    int          idle_after = 0;
    int          lane;
    logic [31:0] pc;
    drain();
    for (int cyc = 0; cyc < 200 && idle_after < 3; cyc++) begin
      @(negedge clk);
      checks++;
      if ({debug_wb_valid, debug_wb_rf_wen, debug_wb_pc, debug_wb_rf_wnum, debug_wb_rf_wdata} !==
          {m_valid, m_out.wen, m_out.pc, m_out.wnum, m_out.wdata}) begin
        errors++;
        $display("[TB] FAIL wrap_out: got v=%b pc=%h wen=%h wnum=%0d wdata=%h, required v=%b pc=%h wen=%h wnum=%0d wdata=%h",
                 debug_wb_valid, debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
                 m_valid, m_out.pc, m_out.wen, m_out.wnum, m_out.wdata);
      end
      if (debug_wb_valid === 1'b1) begin
        checks++;
        if (got >= sent_pc.size() || debug_wb_pc !== sent_pc[got]) begin
          errors++;
          $display("[TB] FAIL wrap_order%0d: got pc=%h, required %h", got, debug_wb_pc,
                   (got < sent_pc.size()) ? sent_pc[got] : 32'h0);
        end
        got++;
      end else if (got > 0) begin
        checks++;
        if (debug_wb_rf_wen !== 4'h0 || debug_wb_pc !== sent_pc[got-1]) begin
          errors++;
          $display("[TB] FAIL wrap_idle_hold: got wen=%h pc=%h, required wen=0 pc=%h", debug_wb_rf_wen, debug_wb_pc, sent_pc[got-1]);
        end
      end
      if (got == 20 && debug_wb_valid !== 1'b1) idle_after++;
      in_valid = '0;
      if (sent_pc.size() < 20) begin
        if (gap == 0) begin
          lane = $urandom_range(0, NCH-1);
          pc   = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
          set_lane(lane, 1'b1, pc, 4'($urandom_range(1, 15)), 5'($urandom), $urandom);
          sent_pc.push_back(pc);
          gap = $urandom_range(0, 3);
        end else begin
          gap--;
        end
      end
    end
    in_valid = '0;
    checks++;
    if (got != 20) begin
      errors++;
      $display("[TB] FAIL wrap_total: got %0d entries, required 20", got);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    in_valid = '0; in_pc = '0; in_wen = '0; in_wnum = '0; in_wdata = '0;
    f_in_valid = '0; f_in_pc = '0; f_in_wen = '0; f_in_wnum = '0; f_in_wdata = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    test_reset();
    test_compaction();
    test_ordering();
    test_backpressure();
    test_filter();
    test_wrap_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
